// File: rtl/openofdm_rx_pkt_packer_pkg.sv
// Shared definitions for the rx packet packer: FSM state encoding, the
// header marker pattern, status-word bit positions and a helper that
// assembles the status word.
package openofdm_rx_pkt_packer_pkg;

  // FIFO entry: {m_last, 64-bit data}
  localparam int WORD_W = 65;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_STATUS = 2'd3
  } state_t;

  localparam logic [15:0] HDR_MARKER = 16'h5A5A;

  localparam int STAT_FCS_OK_BIT  = 0;
  localparam int STAT_OVF_BIT     = 1;
  localparam int STAT_LEN_ERR_BIT = 2;
  localparam int STAT_ABORTED_BIT = 3;

  // Status word: byte count on top, flags in the low nibble. An aborted
  // packet never reports a good FCS.
  function automatic logic [63:0] status_word(
    input logic [15:0] byte_cnt,
    input logic        aborted,
    input logic        len_err,
    input logic        ovf,
    input logic        fcs_ok
  );
    logic [63:0] w;
    w                   = '0;
    w[63:48]            = byte_cnt;
    w[STAT_ABORTED_BIT] = aborted;
    w[STAT_LEN_ERR_BIT] = len_err;
    w[STAT_OVF_BIT]     = ovf;
    w[STAT_FCS_OK_BIT]  = fcs_ok & ~aborted;
    return w;
  endfunction

endpackage

// File: rtl/openofdm_rx_pkt_packer_rx_word_fifo.sv
// Small first-word-fall-through word FIFO. The head entry is read straight
// out of the register array; dout is forced to zero while empty so the
// output bus has a defined value after reset.
// Ports:
//   clock, reset  core clock, asynchronous active-high reset
//   push, din     write request and entry; accepted when not full, or when
//                 full and a pop happens in the same cycle
//   full          all entries occupied
//   pop           remove head entry (ignored when empty)
//   dout, empty   head entry and empty flag
module rx_word_fifo
  import openofdm_rx_pkt_packer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage carries no reset; every entry is written before it can be
  // read, and clearing an array costs a reset net per bit for no benefit.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/openofdm_rx_pkt_packer.sv
// Packs the receiver's decoded byte stream into 64-bit words. Each packet
// becomes one header word, ceil(len/8) data words (little-endian lanes) and
// one status word flagged with m_last, buffered in a small word FIFO.
// Ports:
//   clock, reset               core clock, asynchronous active-high reset
//   pkt_header_*, pkt_rate,    header decode result, sampled on the strobe
//   pkt_len, ht_*, rssi_half_db
//   byte_out_strobe, byte_out  decoded PSDU bytes
//   fcs_out_strobe, fcs_ok     end of PSDU and FCS check result
//   abort                      receiver reset / watchdog
//   m_data, m_last, m_valid,   FIFO head with valid/ready handshake
//   m_ready
//   busy                       a packet is in progress
//   drop_count                 headers dropped on a full FIFO (saturating)
module openofdm_rx_pkt_packer
  import openofdm_rx_pkt_packer_pkg::*;
#(
  parameter int RSSI_HALF_DB_WIDTH = 11,
  parameter int FIFO_DEPTH_LOG2    = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pkt_header_valid_strobe,
  input  logic                          pkt_header_valid,
  input  logic [7:0]                    pkt_rate,
  input  logic [15:0]                   pkt_len,
  input  logic                          ht_aggr,
  input  logic                          ht_aggr_last,
  input  logic                          ht_sgi,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
  input  logic                          byte_out_strobe,
  input  logic [7:0]                    byte_out,
  input  logic                          fcs_out_strobe,
  input  logic                          fcs_ok,
  input  logic                          abort,
  output logic [63:0]                   m_data,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  state_t        state_q, state_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [63:0]   word_q, word_d;
  logic [15:0]   len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          len_err_q, len_err_d;
  logic          aborted_q, aborted_d;
  logic          fcs_q, fcs_d;
  logic [15:0]   drop_q, drop_d;

  logic          push;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] head_word;
  logic          full;
  logic          empty;
  logic [63:0]   hdr_word;

  assign hdr_word = {{(16 - RSSI_HALF_DB_WIDTH){rssi_half_db[RSSI_HALF_DB_WIDTH-1]}},
                     rssi_half_db, pkt_len, pkt_rate, 5'd0,
                     ht_sgi, ht_aggr_last, ht_aggr, HDR_MARKER};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    len_err_d  = len_err_q;
    aborted_d  = aborted_q;
    fcs_d      = fcs_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_word  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pkt_header_valid_strobe && pkt_header_valid && pkt_len != 16'd0) begin
          if (full) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else begin
            push       = 1'b1;
            push_word  = {1'b0, hdr_word};
            byte_cnt_d = '0;
            byte_idx_d = '0;
            word_d     = '0;
            len_d      = pkt_len;
            ovf_d      = 1'b0;
            len_err_d  = 1'b0;
            aborted_d  = 1'b0;
            fcs_d      = 1'b0;
            state_d    = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (abort) begin
          word_d    = '0;
          aborted_d = 1'b1;
          state_d   = ST_STATUS;
        end else begin
          if (byte_out_strobe) begin
            if (byte_cnt_q < len_q) begin
              byte_cnt_d = byte_cnt_q + 16'd1;
              byte_idx_d = byte_idx_q + 3'd1;
              if (byte_idx_q == 3'd7) begin
                // Word complete: it goes out straight from the incoming byte,
                // and the buffer restarts clean so a later partial word has
                // zero in its unused lanes. Once ovf is set the rest of the
                // packet's data is dropped to keep words contiguous.
                word_d = '0;
                if (!ovf_q) begin
                  if (full) begin
                    ovf_d = 1'b1;
                  end else begin
                    push      = 1'b1;
                    push_word = {1'b0, byte_out, word_q[55:0]};
                  end
                end
              end else begin
                word_d[{byte_idx_q, 3'b000} +: 8] = byte_out;
              end
            end else begin
              len_err_d = 1'b1;
            end
          end
          // A coincident byte has already been folded in above.
          if (fcs_out_strobe) begin
            fcs_d   = fcs_ok;
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        word_d  = '0;
        state_d = ST_STATUS;
        if (abort) begin
          aborted_d = 1'b1;
        end else if (byte_idx_q != 3'd0 && !ovf_q) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_word = {1'b0, word_q};
          end
        end
      end

      ST_STATUS: begin
        // The status word is never dropped: hold here until there is room.
        if (!full) begin
          push      = 1'b1;
          push_word = {1'b1, status_word(byte_cnt_q, aborted_q, len_err_q, ovf_q, fcs_q)};
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      len_err_q  <= 1'b0;
      aborted_q  <= 1'b0;
      fcs_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      len_err_q  <= len_err_d;
      aborted_q  <= aborted_d;
      fcs_q      <= fcs_d;
      drop_q     <= drop_d;
    end
  end

  rx_word_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_word),
    .full  (full),
    .pop   (m_valid & m_ready),
    .dout  (head_word),
    .empty (empty)
  );

  assign m_valid    = ~empty;
  assign m_last     = head_word[WORD_W-1];
  assign m_data     = head_word[63:0];
  assign busy       = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_openofdm_rx_pkt_packer.sv
// Bench for openofdm_rx_pkt_packer: directed scenarios plus randomized
// packets, compared against a packet-level model of the output word stream.
module tb_openofdm_rx_pkt_packer;

  localparam int RW = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_header_valid_strobe;
  logic          pkt_header_valid;
  logic [7:0]    pkt_rate;
  logic [15:0]   pkt_len;
  logic          ht_aggr;
  logic          ht_aggr_last;
  logic          ht_sgi;
  logic [RW-1:0] rssi_half_db;
  logic          byte_out_strobe;
  logic [7:0]    byte_out;
  logic          fcs_out_strobe;
  logic          fcs_ok;
  logic          abort;
  logic [63:0]   m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic [15:0]   drop_count;

  always #5 clock = ~clock;

  openofdm_rx_pkt_packer #(
    .RSSI_HALF_DB_WIDTH (RW),
    .FIFO_DEPTH_LOG2    (2)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_header_valid        (pkt_header_valid),
    .pkt_rate                (pkt_rate),
    .pkt_len                 (pkt_len),
    .ht_aggr                 (ht_aggr),
    .ht_aggr_last            (ht_aggr_last),
    .ht_sgi                  (ht_sgi),
    .rssi_half_db            (rssi_half_db),
    .byte_out_strobe         (byte_out_strobe),
    .byte_out                (byte_out),
    .fcs_out_strobe          (fcs_out_strobe),
    .fcs_ok                  (fcs_ok),
    .abort                   (abort),
    .m_data                  (m_data),
    .m_last                  (m_last),
    .m_valid                 (m_valid),
    .m_ready                 (m_ready),
    .busy                    (busy),
    .drop_count              (drop_count)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];
  logic [7:0]  tx_bytes[64];

  // Words accepted by the downstream side; sampled mid-cycle, popped at the
  // following rising edge.
  always @(negedge clock) begin
    if (!reset && m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [64:0] model_hdr(input logic [RW-1:0] rssi, input logic [15:0] len,
                                            input logic [7:0] rate, input logic sgi,
                                            input logic aggr_last, input logic aggr);
    int          r;
    logic [15:0] r16;
    r   = $signed(rssi);
    r16 = 16'(r);
    return {1'b0, r16, len, rate, 5'd0, sgi, aggr_last, aggr, 16'h5A5A};
  endfunction

  function automatic logic [64:0] model_status(input int cnt, input logic aborted,
                                               input logic len_err, input logic ovf,
                                               input logic fcs);
    return {1'b1, 16'(cnt), 44'd0, aborted, len_err, ovf, fcs & ~aborted};
  endfunction

  // Data words for the first nwords*8 bytes (or fewer) of tx_bytes.
  task automatic model_data(input int nbytes, input int max_words);
    logic [63:0] w;
    int          words;
    words = 0;
    for (int k = 0; k < nbytes && words < max_words; k += 8) begin
      w = '0;
      for (int j = 0; j < 8 && k + j < nbytes; j++) w[8*j +: 8] = tx_bytes[k+j];
      exp_q.push_back({1'b0, w});
      words++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_header(input logic [15:0] len, input logic valid, output logic [64:0] hw);
    logic [7:0]    rate;
    logic [RW-1:0] rssi;
    logic [2:0]    fl;
    rate = 8'($urandom);
    rssi = RW'($urandom);
    fl   = 3'($urandom);
    pkt_rate = rate; pkt_len = len; rssi_half_db = rssi;
    ht_sgi = fl[2]; ht_aggr_last = fl[1]; ht_aggr = fl[0];
    pkt_header_valid = valid;
    pkt_header_valid_strobe = 1'b1;
    tick();
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid = 1'b0;
    hw = model_hdr(rssi, len, rate, fl[2], fl[1], fl[0]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_out = b;
    byte_out_strobe = 1'b1;
    tick();
    byte_out_strobe = 1'b0;
  endtask

  task automatic send_fcs(input logic ok);
    fcs_ok = ok;
    fcs_out_strobe = 1'b1;
    tick();
    fcs_out_strobe = 1'b0;
    fcs_ok = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || m_valid) && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, {63'd0, busy, m_valid}, 65'd0);
    check({tag, "_count"}, 65'(got_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Full packet with the downstream always ready; nsent may exceed len.
  task automatic run_pkt(input string tag, input int len, input int nsent,
                         input logic fcs, input bit gaps);
    logic [64:0] hw;
    int          nacc;
    send_header(16'(len), 1'b1, hw);
    exp_q.push_back(hw);
    for (int i = 0; i < nsent; i++) begin
      send_byte(tx_bytes[i]);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
    send_fcs(fcs);
    nacc = (nsent < len) ? nsent : len;
    model_data(nacc, 1000);
    exp_q.push_back(model_status(nacc, 1'b0, nsent > len, 1'b0, fcs));
    drain(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"}, 65'(m_valid), 65'd0);
    check({tag, "_m_data"}, 65'(m_data), 65'd0);
    check({tag, "_m_last"}, 65'(m_last), 65'd0);
    check({tag, "_busy"}, 65'(busy), 65'd0);
    check({tag, "_drop"}, 65'(drop_count), 65'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [64:0] hw;
    logic [64:0] head;
    int          len;
    int          extra;

    reset = 1'b1;
    pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0;
    pkt_rate = '0; pkt_len = '0; ht_aggr = 1'b0; ht_aggr_last = 1'b0; ht_sgi = 1'b0;
    rssi_half_db = '0; byte_out_strobe = 1'b0; byte_out = '0;
    fcs_out_strobe = 1'b0; fcs_ok = 1'b0; abort = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Sequential bytes 0x01..0x0C: one full word, one partial word.
    for (int i = 0; i < 12; i++) tx_bytes[i] = 8'(i + 1);
    run_pkt("len12", 12, 12, 1'b1, 1'b0);

    // Exact multiple of 8: no partial flush word.
    for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
    run_pkt("len16", 16, 16, 1'b0, 1'b0);

    // Bytes beyond pkt_len are ignored and flagged.
    for (int i = 0; i < 11; i++) tx_bytes[i] = 8'($urandom);
    run_pkt("len_err", 8, 11, 1'b1, 1'b0);

    // Randomized packets, sometimes overrunning pkt_len.
    for (int p = 0; p < 6; p++) begin
      len   = $urandom_range(1, 40);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < len + extra; i++) tx_bytes[i] = 8'($urandom);
      run_pkt($sformatf("rand%0d", p), len, len + extra, 1'($urandom), 1'b1);
    end

    // Stalled downstream: header + 3 words fill the FIFO, the rest overflows,
    // and the status word waits for room.
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) tx_bytes[i] = 8'($urandom);
    send_header(16'd40, 1'b1, hw);
    exp_q.push_back(hw);
    for (int i = 0; i < 40; i++) send_byte(tx_bytes[i]);
    send_fcs(1'b1);
    repeat (5) tick();
    check("ovf_busy_waiting", 65'(busy), 65'd1);
    check("ovf_head", {m_last, m_data}, hw);
    head = {m_last, m_data};
    repeat (3) tick();
    check("ovf_head_stable", {m_last, m_data}, head);
    model_data(40, 3);
    exp_q.push_back(model_status(40, 1'b0, 1'b0, 1'b1, 1'b1));
    m_ready = 1'b1;
    drain("ovf");

    // Abort after 5 bytes: no data word, aborted status with fcs forced 0.
    for (int i = 0; i < 5; i++) tx_bytes[i] = 8'($urandom);
    send_header(16'd20, 1'b1, hw);
    exp_q.push_back(hw);
    for (int i = 0; i < 5; i++) send_byte(tx_bytes[i]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    send_fcs(1'b1);
    exp_q.push_back(model_status(5, 1'b1, 1'b0, 1'b0, 1'b1));
    drain("abort");

    // Abort while idle does nothing.
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    check("abort_idle_busy", {63'd0, busy, m_valid}, 65'd0);

    // Fill the FIFO with a 4-word packet, then offer headers while full.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
    send_header(16'd16, 1'b1, hw);
    exp_q.push_back(hw);
    for (int i = 0; i < 16; i++) send_byte(tx_bytes[i]);
    send_fcs(1'b1);
    model_data(16, 2);
    exp_q.push_back(model_status(16, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (4) tick();
    check("full_idle", {63'd0, busy, m_valid}, 65'd1);
    send_header(16'd5, 1'b1, hw);
    tick();
    check("drop_once", 65'(drop_count), 65'd1);
    check("drop_not_busy", 65'(busy), 65'd0);
    send_header(16'd5, 1'b0, hw);
    send_header(16'd0, 1'b1, hw);
    tick();
    check("drop_ignored", 65'(drop_count), 65'd1);
    m_ready = 1'b1;
    drain("full");

    // Header not valid / zero length on an empty FIFO: ignored.
    send_header(16'd9, 1'b0, hw);
    tick();
    check("hdr_invalid", {63'd0, busy, m_valid}, 65'd0);
    send_header(16'd0, 1'b1, hw);
    tick();
    check("hdr_len0", {63'd0, busy, m_valid}, 65'd0);

    // Reset in the middle of a packet clears everything at once.
    send_header(16'd20, 1'b1, hw);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    tick();
    reset = 1'b0;
    tick();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) tx_bytes[i] = 8'($urandom);
    run_pkt("recover", 10, 10, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
